imem_sync: RTL and testbench

IMEM_SYNC -- requirements
Module: imem_sync

---
 rtl/lc2k_pkg.sv | 29 ++
 rtl/imem_ram.sv | 24 ++
 rtl/imem_sync.sv | 87 ++++++++
 tb/tb_imem_sync.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lc2k_pkg.sv
// rtl/lc2k_pkg.sv - shared LC2K constants, opcodes and instruction-memory FSM states
package lc2k_pkg;

  // LC2K halt: opcode 6 in bits 24:22, all other fields zero
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'd25165824;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_NOR  = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_JALR = 3'd5,
    OP_HALT = 3'd6,
    OP_NOOP = 3'd7
  } lc2k_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } imem_state_e;

  // Packs an LC2K word: opcode[24:22], regA[21:19], regB[18:16], low field[15:0]
  function automatic logic [31:0] lc2k_encode(lc2k_op_e op, logic [2:0] ra,
                                              logic [2:0] rb, logic [15:0] lo);
    return {7'd0, op, ra, rb, lo};
  endfunction

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - single-write, single synchronous-read instruction word storage
module imem_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  // Contents carry no reset so a program survives rst_n pulses
  logic [31:0] mem [DEPTH];

  // Read-first port: a same-edge write is seen by the following read only
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_sync.sv
// rtl/imem_sync.sv - loadable LC2K instruction memory with valid/ready fetch port
module imem_sync
  import lc2k_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          PC_W      = 32,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     loadEn,
  input  logic                     ldValid,
  input  logic [$clog2(DEPTH)-1:0] ldAddr,
  input  logic [31:0]              ldData,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [PC_W-1:0]          pcCurrent,
  output logic                     rspValid,
  input  logic                     rspReady,
  output logic [31:0]              instr,
  output logic                     fault
);

  localparam int AW = $clog2(DEPTH);

  imem_state_e state, state_nxt;
  logic        accept;
  logic        oob;
  logic        rsp_free;
  logic        fault_q;
  logic [31:0] ram_rdata;

  // Response slot can take new data when empty or being drained this cycle
  assign rsp_free = !rspValid || rspReady;
  assign reqReady = (state == ST_RUN) && rsp_free && !loadEn;
  assign accept   = reqValid && reqReady;
  // Compare the whole PC so high bits never alias onto a valid word
  assign oob      = 64'(pcCurrent) >= 64'(DEPTH);

  imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (state == ST_LOAD && ldValid),
    .waddr (ldAddr),
    .wdata (ldData),
    .re    (accept && !oob),
    .raddr (pcCurrent[AW-1:0]),
    .rdata (ram_rdata)
  );

  // State register and response slot; response is dropped outright on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      rspValid <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rspValid <= 1'b1;
        fault_q  <= oob;
      end else if (rspReady) begin
        rspValid <= 1'b0;
      end
    end
  end

  // Enter LOAD only once no response is left stranded; leave when loadEn drops
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (loadEn && rsp_free) state_nxt = ST_LOAD;
      ST_LOAD: if (!loadEn)            state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs are zero with no response, so reset clears instr without touching the RAM
  always_comb begin
    instr = 32'd0;
    fault = 1'b0;
    if (rspValid) begin
      fault = fault_q;
      instr = fault_q ? HALT_WORD : ram_rdata;
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// tb/tb_imem_sync.sv - directed-vector bench for imem_sync
module tb_imem_sync;

  localparam int DEPTH = 64;
  localparam int PC_W  = 40;
  localparam logic [31:0] HALT = 32'd25165824;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            loadEn;
  logic            ldValid;
  logic [5:0]      ldAddr;
  logic [31:0]     ldData;
  logic            reqValid;
  logic            reqReady;
  logic [PC_W-1:0] pcCurrent;
  logic            rspValid;
  logic            rspReady;
  logic [31:0]     instr;
  logic            fault;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] prog [7];

  imem_sync #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .loadEn    (loadEn),
    .ldValid   (ldValid),
    .ldAddr    (ldAddr),
    .ldData    (ldData),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .pcCurrent (pcCurrent),
    .rspValid  (rspValid),
    .rspReady  (rspReady),
    .instr     (instr),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic rsp_is(input string tag, input logic [31:0] w, input logic f);
    check({tag, ".valid"}, 64'(rspValid), 64'd1);
    check({tag, ".instr"}, 64'(instr), 64'(w));
    check({tag, ".fault"}, 64'(fault), 64'(f));
  endtask

  initial begin
    // jalr test program: lw 0 2 7 / lw 0 3 8 / jalr 2 4 / add 3 3 3 / noop / halt / .fill 5
    prog[0] = 32'd8519687;
    prog[1] = 32'd8585224;
    prog[2] = 32'd22282240;
    prog[3] = 32'd1769475;
    prog[4] = 32'd29360128;
    prog[5] = 32'd25165824;
    prog[6] = 32'd5;

    rst_n = 1'b0; loadEn = 1'b0; ldValid = 1'b0; ldAddr = '0; ldData = '0;
    reqValid = 1'b0; pcCurrent = '0; rspReady = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.valid", 64'(rspValid), 64'd0);
    check("rst.instr", 64'(instr), 64'd0);
    check("rst.fault", 64'(fault), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.ready", 64'(reqReady), 64'd1);

    // load the program
    loadEn = 1'b1;
    #1 check("loaden.ready", 64'(reqReady), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      ldValid = 1'b1; ldAddr = 6'(i); ldData = prog[i];
      @(negedge clk);
      check("load.ready", 64'(reqReady), 64'd0);
    end
    ldValid = 1'b0; loadEn = 1'b0;
    @(negedge clk);
    check("run.ready", 64'(reqReady), 64'd1);

    // back-to-back fetch of 0..6
    reqValid = 1'b1; rspReady = 1'b1; pcCurrent = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rsp_is($sformatf("seq%0d", i), prog[i], 1'b0);
      if (i < 6) pcCurrent = PC_W'(i + 1);
      else reqValid = 1'b0;
    end
    @(negedge clk);
    check("seq.drain", 64'(rspValid), 64'd0);

    // out-of-range fetches, including one that would alias word 3 if truncated
    reqValid = 1'b1; pcCurrent = 40'd64;
    @(negedge clk);
    rsp_is("oob64", HALT, 1'b1);
    pcCurrent = 40'h1_0000_0003;
    @(negedge clk);
    rsp_is("oobwide", HALT, 1'b1);
    reqValid = 1'b0;
    @(negedge clk);
    check("oob.drain", 64'(rspValid), 64'd0);

    // stalled response holds and blocks new requests
    reqValid = 1'b1; pcCurrent = 40'd2; rspReady = 1'b0;
    @(negedge clk);
    pcCurrent = 40'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      rsp_is($sformatf("stall%0d", i), prog[2], 1'b0);
      check("stall.ready", 64'(reqReady), 64'd0);
      @(negedge clk);
    end
    reqValid = 1'b0; rspReady = 1'b1;
    @(negedge clk);
    check("stall.drain", 64'(rspValid), 64'd0);

    // loadEn while stalled: stay in RUN, RUN-mode writes ignored
    reqValid = 1'b1; pcCurrent = 40'd4;
    @(negedge clk);
    reqValid = 1'b0; rspReady = 1'b0; loadEn = 1'b1;
    ldValid = 1'b1; ldAddr = 6'd4; ldData = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      rsp_is("ldstall", prog[4], 1'b0);
    end
    ldValid = 1'b0; rspReady = 1'b1;
    @(negedge clk);
    check("ldstall.drain", 64'(rspValid), 64'd0);
    ldValid = 1'b1; ldAddr = 6'd7; ldData = 32'h0000_1234;
    @(negedge clk);
    ldValid = 1'b0; loadEn = 1'b0;
    @(negedge clk);
    reqValid = 1'b1; pcCurrent = 40'd4;
    @(negedge clk);
    rsp_is("runwr.ignored", prog[4], 1'b0);
    pcCurrent = 40'd7;
    @(negedge clk);
    rsp_is("loadwr.taken", 32'h0000_1234, 1'b0);

    // reset mid-stream drops the response immediately, memory persists
    pcCurrent = 40'd1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst.valid", 64'(rspValid), 64'd0);
    check("midrst.instr", 64'(instr), 64'd0);
    check("midrst.fault", 64'(fault), 64'd0);
    reqValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst.valid", 64'(rspValid), 64'd0);
    reqValid = 1'b1; pcCurrent = 40'd0;
    @(negedge clk);
    rsp_is("postrst.pc0", 32'd8519687, 1'b0);
    reqValid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
